switch_traffic_gen: RTL and testbench

- Synthesizable packet injector that drives flits into one switch input port, using credit-based flow control per VC.
- Generates head/body/tail packets with a programmable length. Injection is gated by an LFSR against a programmable rate.
- Keeps packet, flit and credit-stall counters so measured switch activity can be cross-checked against what was offered.
- Sits upstream of a switch input buffer, in the benches and in on-chip self-test.

---
 rtl/switch_traffic_gen.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_switch_traffic_gen.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_traffic_gen.sv
// ---------------------------------------------------------------------------
// switch_traffic_gen
//
// Packet injector feeding one switch input port. Packets of a programmable
// length (head, body..., tail) are started from IDLE whenever an LFSR draw
// falls below the programmed injection rate. Flits leave only when the
// downstream per-VC buffer has space, tracked with credit counters that are
// replenished through credit_return. Packet, flit and stall counters record
// what was actually offered so switch activity can be cross-checked.
//
// Optional build macro:
//   TRAFFIC_GEN_CHECKSUM_EN - appends one checksum flit (XOR of every
//                             previous flit_data word of the packet); the
//                             tail marker moves onto that flit.
//
// Ports:
//   clk            clock
//   n_rst          asynchronous active-low reset
//   enable         allows new packets to start (never truncates one)
//   inject_rate    0 never, 255 every IDLE cycle, else lfsr[7:0] < rate
//   pkt_len        flits per packet incl. head (0 -> 1, clamped to max)
//   credit_return  one credit back per set bit per cycle
//   flit_valid     registered flit strobe
//   flit_vc        VC of the current flit
//   flit_head      first flit of a packet
//   flit_tail      last flit of a packet
//   flit_data      flit payload
//   busy           a packet is in progress
//   credit_err     sticky: credit returned to a VC already at full credit
//   pkts_sent      completed packets
//   flits_sent     emitted flits
//   stall_cycles   SEND cycles blocked by zero credit
// ---------------------------------------------------------------------------
module switch_traffic_gen #(
    parameter int          NUM_VCS     = 2,
    parameter int          BUFFER_SIZE = 8,
    parameter int          TOTAL_NODES = 4,
    parameter int          NODE        = 0,
    parameter int          FLIT_WIDTH  = 32,
    parameter int          MAX_PKT_LEN = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         VC_W        = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int         LEN_W       = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  enable,
    input  logic [7:0]            inject_rate,
    input  logic [LEN_W-1:0]      pkt_len,
    input  logic [NUM_VCS-1:0]    credit_return,
    output logic                  flit_valid,
    output logic [VC_W-1:0]       flit_vc,
    output logic                  flit_head,
    output logic                  flit_tail,
    output logic [FLIT_WIDTH-1:0] flit_data,
    output logic                  busy,
    output logic                  credit_err,
    output logic [31:0]           pkts_sent,
    output logic [31:0]           flits_sent,
    output logic [31:0]           stall_cycles
);

    localparam int          CRED_W     = $clog2(BUFFER_SIZE + 1);
    localparam logic [15:0] LFSR_INIT  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [7:0]  FIRST_DEST = (NODE == 0) ? 8'd1 : 8'd0;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [15:0]           lfsr;
    logic [CRED_W-1:0]     credit [NUM_VCS];
    logic [15:0]           seq;
    logic [7:0]            next_dest;
    logic [7:0]            dest;
    logic [VC_W-1:0]       next_vc;
    logic [VC_W-1:0]       vc;
    logic [LEN_W-1:0]      len;
    logic [15:0]           idx;

    logic                  start;
    logic                  can_send;
    logic                  stalled;
    logic                  is_last;
    logic [15:0]           last_idx;
    logic [LEN_W-1:0]      clamped_len;
    logic [7:0]            len8;
    logic [FLIT_WIDTH-1:0] payload;
    logic [FLIT_WIDTH-1:0] out_word;
    logic [NUM_VCS-1:0]    send_on;
    logic [NUM_VCS-1:0]    overflow;

`ifdef TRAFFIC_GEN_CHECKSUM_EN
    logic [FLIT_WIDTH-1:0] csum;
`endif

    // Round-robin destination step that never lands on our own node id.
    function automatic logic [7:0] advance_dest(input logic [7:0] d);
        logic [7:0] n;
        n = (d == 8'(TOTAL_NODES - 1)) ? 8'd0 : d + 8'd1;
        if (n == 8'(NODE)) begin
            n = (n == 8'(TOTAL_NODES - 1)) ? 8'd0 : n + 8'd1;
        end
        return n;
    endfunction

    assign busy = (state != IDLE);
    assign len8 = 8'(len);

    // The checksum build carries one extra flit, so its last index is len
    // rather than len-1.
`ifdef TRAFFIC_GEN_CHECKSUM_EN
    assign last_idx = 16'(len);
`else
    assign last_idx = 16'(len) - 16'd1;
`endif

    // Injection decision, send qualification and length clamping.
    always_comb begin
        start    = (state == IDLE) && enable &&
                   ((inject_rate == 8'hFF) || (lfsr[7:0] < inject_rate));
        can_send = (state == SEND) && (credit[vc] != '0);
        stalled  = (state == SEND) && (credit[vc] == '0);
        is_last  = (idx == last_idx);
        if (pkt_len == '0) begin
            clamped_len = LEN_W'(1);
        end else if (pkt_len > LEN_W'(MAX_PKT_LEN)) begin
            clamped_len = LEN_W'(MAX_PKT_LEN);
        end else begin
            clamped_len = pkt_len;
        end
    end

    // Flit word assembly; everything above bit 31 stays zero.
    always_comb begin
        payload = '0;
        if (idx == 16'd0) begin
            payload[31:0] = {seq, len8, dest};
        end else begin
            payload[31:0] = {seq, idx};
        end
`ifdef TRAFFIC_GEN_CHECKSUM_EN
        out_word = is_last ? csum : payload;
`else
        out_word = payload;
`endif
    end

    // Per-VC credit events: which VC is sending and which return would
    // push a counter past the buffer depth.
    always_comb begin
        send_on  = '0;
        overflow = '0;
        for (int i = 0; i < NUM_VCS; i++) begin
            send_on[i]  = can_send && (vc == VC_W'(i));
            overflow[i] = credit_return[i] && !send_on[i] &&
                          (credit[i] == CRED_W'(BUFFER_SIZE));
        end
    end

    // Next-state logic: leave SEND only once the tail has gone out.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SEND;
            SEND:    if (can_send && is_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lfsr <= LFSR_INIT;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Packet context: latched at start, flit index advances per sent flit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            len       <= '0;
            dest      <= '0;
            vc        <= '0;
            idx       <= '0;
            next_dest <= FIRST_DEST;
            next_vc   <= '0;
            seq       <= '0;
        end else begin
            if (start) begin
                len       <= clamped_len;
                dest      <= next_dest;
                vc        <= next_vc;
                idx       <= '0;
                next_dest <= advance_dest(next_dest);
                next_vc   <= (next_vc == VC_W'(NUM_VCS - 1)) ? '0 : next_vc + 1'b1;
            end else if (can_send) begin
                idx <= idx + 16'd1;
                if (is_last) begin
                    seq <= seq + 16'd1;
                end
            end
        end
    end

`ifdef TRAFFIC_GEN_CHECKSUM_EN
    // Running XOR of every flit word already sent in this packet.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            csum <= '0;
        end else if (start) begin
            csum <= '0;
        end else if (can_send) begin
            csum <= csum ^ out_word;
        end
    end
`endif

    // Registered flit outputs; fields are cleared when no flit is present.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            flit_valid <= 1'b0;
            flit_vc    <= '0;
            flit_head  <= 1'b0;
            flit_tail  <= 1'b0;
            flit_data  <= '0;
        end else begin
            flit_valid <= can_send;
            flit_vc    <= can_send ? vc : '0;
            flit_head  <= can_send && (idx == 16'd0);
            flit_tail  <= can_send && is_last;
            flit_data  <= can_send ? out_word : '0;
        end
    end

    // Credit counters: a simultaneous send and return cancel out, and a
    // return to a full counter is dropped and flagged.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_VCS; i++) begin
                credit[i] <= CRED_W'(BUFFER_SIZE);
            end
        end else begin
            for (int i = 0; i < NUM_VCS; i++) begin
                if (send_on[i] && !credit_return[i]) begin
                    credit[i] <= credit[i] - 1'b1;
                end else if (credit_return[i] && !send_on[i] && !overflow[i]) begin
                    credit[i] <= credit[i] + 1'b1;
                end
            end
        end
    end

    // Activity counters and the sticky credit error flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pkts_sent    <= '0;
            flits_sent   <= '0;
            stall_cycles <= '0;
            credit_err   <= 1'b0;
        end else begin
            if (can_send) begin
                flits_sent <= flits_sent + 32'd1;
            end
            if (can_send && is_last) begin
                pkts_sent <= pkts_sent + 32'd1;
            end
            if (stalled) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (|overflow) begin
                credit_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_switch_traffic_gen.sv
// ---------------------------------------------------------------------------
// tb_switch_traffic_gen
//
// Bench for switch_traffic_gen. A packet-level model (whole packets built as
// flit queues when they start, credits as plain integers) predicts every
// output each cycle; a negedge process compares the DUT against it. Directed
// phases pin the model with hand-computed literals, then a randomized phase
// drives enable/rate/length and credit returns.
// ---------------------------------------------------------------------------
module tb_switch_traffic_gen;

    localparam int          NUM_VCS     = 2;
    localparam int          BUFFER_SIZE = 8;
    localparam int          TOTAL_NODES = 4;
    localparam int          NODE        = 0;
    localparam int          FLIT_WIDTH  = 32;
    localparam int          MAX_PKT_LEN = 16;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    localparam int          LEN_W       = $clog2(MAX_PKT_LEN + 1);
    localparam int          VC_W        = 1;
`ifdef TRAFFIC_GEN_CHECKSUM_EN
    localparam int          CK          = 1;
`else
    localparam int          CK          = 0;
`endif

    logic                  clk;
    logic                  n_rst;
    logic                  enable;
    logic [7:0]            inject_rate;
    logic [LEN_W-1:0]      pkt_len;
    logic [NUM_VCS-1:0]    credit_return;
    logic                  flit_valid;
    logic [VC_W-1:0]       flit_vc;
    logic                  flit_head;
    logic                  flit_tail;
    logic [FLIT_WIDTH-1:0] flit_data;
    logic                  busy;
    logic                  credit_err;
    logic [31:0]           pkts_sent;
    logic [31:0]           flits_sent;
    logic [31:0]           stall_cycles;

    int total;
    int bad;

    switch_traffic_gen #(
        .NUM_VCS    (NUM_VCS),
        .BUFFER_SIZE(BUFFER_SIZE),
        .TOTAL_NODES(TOTAL_NODES),
        .NODE       (NODE),
        .FLIT_WIDTH (FLIT_WIDTH),
        .MAX_PKT_LEN(MAX_PKT_LEN),
        .LFSR_SEED  (LFSR_SEED)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable       (enable),
        .inject_rate  (inject_rate),
        .pkt_len      (pkt_len),
        .credit_return(credit_return),
        .flit_valid   (flit_valid),
        .flit_vc      (flit_vc),
        .flit_head    (flit_head),
        .flit_tail    (flit_tail),
        .flit_data    (flit_data),
        .busy         (busy),
        .credit_err   (credit_err),
        .pkts_sent    (pkts_sent),
        .flits_sent   (flits_sent),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------
    // Packet-level reference model
    // ---------------------------------------------------------------
    typedef struct {
        logic [31:0] data;
        bit          head;
        bit          tail;
    } mflit_t;

    mflit_t      m_q[$];
    int          m_credit [NUM_VCS];
    bit          m_active;
    int          m_vc;
    int          m_next_dest;
    int          m_next_vc;
    logic [15:0] m_seq;
    logic [15:0] m_lfsr;
    logic [31:0] m_pkts;
    logic [31:0] m_flits;
    logic [31:0] m_stall;
    bit          m_err;

    bit          exp_valid;
    int          exp_vc;
    bit          exp_head;
    bit          exp_tail;
    logic [31:0] exp_data;
    bit          exp_busy;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic model_reset();
        m_q.delete();
        for (int v = 0; v < NUM_VCS; v++) m_credit[v] = BUFFER_SIZE;
        m_active    = 0;
        m_vc        = 0;
        m_next_dest = (NODE == 0) ? 1 : 0;
        m_next_vc   = 0;
        m_seq       = '0;
        m_lfsr      = (LFSR_SEED == 16'h0) ? 16'h1 : LFSR_SEED;
        m_pkts      = '0;
        m_flits     = '0;
        m_stall     = '0;
        m_err       = 0;
        exp_valid   = 0;
        exp_vc      = 0;
        exp_head    = 0;
        exp_tail    = 0;
        exp_data    = '0;
        exp_busy    = 0;
    endtask

    // Build the whole packet up front as the list of flits it must emit.
    task automatic build_packet();
        int          len;
        int          dest;
        logic [31:0] x;
        mflit_t      f;
        len  = (pkt_len == 0) ? 1 : ((int'(pkt_len) > MAX_PKT_LEN) ? MAX_PKT_LEN : int'(pkt_len));
        dest = m_next_dest;
        m_vc = m_next_vc;
        x    = '0;
        for (int i = 0; i < len; i++) begin
            f.data = (i == 0) ? {m_seq, 8'(len), 8'(dest)} : {m_seq, 16'(i)};
            f.head = (i == 0);
            f.tail = (CK == 0) && (i == len - 1);
            x      = x ^ f.data;
            m_q.push_back(f);
        end
        if (CK != 0) begin
            f.data = x;
            f.head = 0;
            f.tail = 1;
            m_q.push_back(f);
        end
        m_active = 1;
        do m_next_dest = (m_next_dest + 1) % TOTAL_NODES; while (m_next_dest == NODE);
        m_next_vc = (m_next_vc + 1) % NUM_VCS;
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_step();
        bit     send;
        bit     s;
        bit     r;
        mflit_t f;
        exp_valid = 0;
        exp_vc    = 0;
        exp_head  = 0;
        exp_tail  = 0;
        exp_data  = '0;
        send      = 0;
        if (!m_active) begin
            if (enable && (inject_rate == 8'hFF || m_lfsr[7:0] < inject_rate)) build_packet();
        end else if (m_credit[m_vc] > 0) begin
            f         = m_q.pop_front();
            exp_valid = 1;
            exp_vc    = m_vc;
            exp_head  = f.head;
            exp_tail  = f.tail;
            exp_data  = f.data;
            send      = 1;
            m_flits   = m_flits + 1;
            if (m_q.size() == 0) begin
                m_active = 0;
                m_pkts   = m_pkts + 1;
                m_seq    = m_seq + 1;
            end
        end else begin
            m_stall = m_stall + 1;
        end
        for (int v = 0; v < NUM_VCS; v++) begin
            s = send && (m_vc == v);
            r = credit_return[v];
            if (s && !r) m_credit[v] = m_credit[v] - 1;
            else if (r && !s) begin
                if (m_credit[v] == BUFFER_SIZE) m_err = 1;
                else m_credit[v] = m_credit[v] + 1;
            end
        end
        m_lfsr   = lfsr_next(m_lfsr);
        exp_busy = m_active;
    endtask

    // Single comparison point: counts every check and reports failures.
    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                model_reset();
                check_output("rst_valid", 64'(flit_valid), 0);
                check_output("rst_vc",    64'(flit_vc), 0);
                check_output("rst_head",  64'(flit_head), 0);
                check_output("rst_tail",  64'(flit_tail), 0);
                check_output("rst_data",  64'(flit_data), 0);
                check_output("rst_busy",  64'(busy), 0);
                check_output("rst_err",   64'(credit_err), 0);
                check_output("rst_pkts",  64'(pkts_sent), 0);
                check_output("rst_flits", 64'(flits_sent), 0);
                check_output("rst_stall", 64'(stall_cycles), 0);
            end else begin
                check_output("valid", 64'(flit_valid),   64'(exp_valid));
                check_output("busy",  64'(busy),         64'(exp_busy));
                check_output("err",   64'(credit_err),   64'(m_err));
                check_output("pkts",  64'(pkts_sent),    64'(m_pkts));
                check_output("flits", 64'(flits_sent),   64'(m_flits));
                check_output("stall", 64'(stall_cycles), 64'(m_stall));
                if (exp_valid) begin
                    check_output("vc",   64'(flit_vc),   64'(exp_vc));
                    check_output("head", 64'(flit_head), 64'(exp_head));
                    check_output("tail", 64'(flit_tail), 64'(exp_tail));
                    check_output("data", 64'(flit_data), 64'(exp_data));
                end
                model_step();
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    int         mode;
    int         seen;
    logic [1:0] pipe0;
    logic [1:0] pipe1;
    int         outst [NUM_VCS];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input bit en, input logic [7:0] rate, input logic [LEN_W-1:0] len);
        enable      = en;
        inject_rate = rate;
        pkt_len     = len;
    endtask

    // One clock, then observe the flit and choose next credit returns.
    // mode 0: no returns, 1: loopback two cycles later, 2: random returns.
    task automatic step_cycle();
        logic [1:0] nr;
        tick();
        nr = flit_valid ? (2'b01 << flit_vc) : 2'b00;
        if (flit_valid) begin
            seen++;
            outst[flit_vc]++;
        end
        case (mode)
            1: begin
                credit_return = pipe1;
                pipe1         = pipe0;
                pipe0         = nr;
            end
            2: begin
                for (int v = 0; v < NUM_VCS; v++) begin
                    credit_return[v] = 1'b0;
                    if (outst[v] > 0 && $urandom_range(0, 2) == 0) begin
                        credit_return[v] = 1'b1;
                        outst[v]--;
                    end else if (outst[v] == 0 && $urandom_range(0, 299) == 0) begin
                        credit_return[v] = 1'b1;
                    end
                end
            end
            default: credit_return = '0;
        endcase
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) step_cycle();
    endtask

    task automatic wait_flits(input int target, input int budget, input string name);
        int c;
        c = 0;
        while (seen < target && c < budget) begin
            step_cycle();
            c++;
        end
        check_output(name, 64'(seen >= target), 1);
    endtask

    task automatic reset_dut();
        n_rst         = 1'b0;
        credit_return = '0;
        pipe0         = '0;
        pipe1         = '0;
        for (int v = 0; v < NUM_VCS; v++) outst[v] = 0;
        seen = 0;
        tick();
        tick();
        n_rst = 1'b1;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        mode          = 0;
        n_rst         = 1'b0;
        enable        = 1'b0;
        inject_rate   = 8'd0;
        pkt_len       = '0;
        credit_return = '0;

        // Rate zero: nothing may ever be injected.
        apply_stimulus(1'b1, 8'd0, 5'd4);
        reset_dut();
        run_cycles(100);
        check_output("idle_flits", 64'(flits_sent), 0);
        check_output("idle_pkts",  64'(pkts_sent), 0);
        check_output("idle_busy",  64'(busy), 0);

        // Zero length becomes single-flit packets: seq 0, len 1, dest 1.
        mode = 1;
        apply_stimulus(1'b1, 8'hFF, 5'd0);
        reset_dut();
        wait_flits(1, 10, "wait_len0");
        check_output("len0_data", 64'(flit_data), 64'h0000_0101);
        check_output("len0_head", 64'(flit_head), 1);
        check_output("len0_tail", 64'(flit_tail), 64'(CK == 0));
        run_cycles(30);

        // Four-flit packets with looped-back credits.
        apply_stimulus(1'b1, 8'hFF, 5'd4);
        reset_dut();
        wait_flits(1, 10, "wait_p4_first");
        check_output("p4_head0", 64'(flit_data), 64'h0000_0401);
        check_output("p4_vc0",   64'(flit_vc), 0);
        wait_flits(4 + CK + 1, 20, "wait_p4_second");
        check_output("p4_head1", 64'(flit_data), 64'h0001_0402);
        check_output("p4_vc1",   64'(flit_vc), 1);
        run_cycles(50);

        // Three-flit packet: fourth flit is the checksum or the next head.
        apply_stimulus(1'b1, 8'hFF, 5'd3);
        reset_dut();
        wait_flits(4, 20, "wait_p3");
        check_output("p3_fourth", 64'(flit_data), (CK != 0) ? 64'h0000_0302 : 64'h0001_0302);
        run_cycles(20);

        // Twelve-flit packet with no credit returns: 8 flits then stalls.
        mode = 0;
        apply_stimulus(1'b1, 8'hFF, 5'd12);
        reset_dut();
        tick();
        enable = 1'b0;
        run_cycles(29);
        check_output("p12_flits", 64'(flits_sent), 8);
        check_output("p12_stall", 64'(stall_cycles), 21);
        check_output("p12_busy",  64'(busy), 1);
        for (int i = 0; i < 4 + CK; i++) begin
            credit_return = 2'b01;
            tick();
        end
        credit_return = '0;
        run_cycles(20);
        check_output("p12_pkts",  64'(pkts_sent), 1);
        check_output("p12_total", 64'(flits_sent), 64'(12 + CK));

        // Return to VC1 while it is already full: sticky error.
        credit_return = 2'b10;
        tick();
        credit_return = '0;
        check_output("cerr_set", 64'(credit_err), 1);
        run_cycles(5);
        check_output("cerr_hold", 64'(credit_err), 1);

        // Reset on the third flit of a six-flit packet.
        mode = 1;
        apply_stimulus(1'b1, 8'hFF, 5'd6);
        reset_dut();
        wait_flits(3, 20, "wait_p6");
        n_rst = 1'b0;
        #1;
        check_output("abort_valid", 64'(flit_valid), 0);
        check_output("abort_flits", 64'(flits_sent), 0);
        check_output("abort_err",   64'(credit_err), 0);
        reset_dut();
        wait_flits(1, 10, "wait_p6_after");
        check_output("after_head", 64'(flit_head), 1);
        check_output("after_data", 64'(flit_data), 64'h0000_0601);

        // Randomized traffic with credits returned from outstanding flits.
        mode = 2;
        reset_dut();
        for (int blk = 0; blk < 200; blk++) begin
            enable = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
                0:       inject_rate = 8'd0;
                1:       inject_rate = 8'hFF;
                default: inject_rate = 8'($urandom_range(0, 255));
            endcase
            pkt_len = 5'($urandom_range(0, 31));
            run_cycles(8);
        end
        check_output("rand_some_pkts", 64'(pkts_sent > 0), 1);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
